// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: HI/LO unit op encodings, default latencies and op-class helpers.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_long_op(input logic [2:0] op);
        return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return op inside {MDU_DIV, MDU_DIVU};
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: E-stage operand/command bundle and HI/LO/hazard outputs of the MD unit.
interface mult_div_unit_if;

    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        StallReq;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output Start, MDOp, A, B, input Busy, StallReq, HI, LO);
    modport slave  (input Start, MDOp, A, B, output Busy, StallReq, HI, LO);

endinterface

// File: rtl/mult_div_unit_datapath.sv
// mult_div_unit_datapath: combinational (op, A, B) -> {PH, PL} plus divide-by-zero flag.
module mult_div_unit_datapath
    import mult_div_unit_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] ph,
    output logic [31:0] pl,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic        signed_div;
    logic        b_zero;

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        prod_s      = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u      = {32'd0, a} * {32'd0, b};
        signed_div  = md_op == MDU_DIV;
        b_zero      = b == 32'd0;
        div_by_zero = is_div_op(md_op) && b_zero;
        mag_a       = (signed_div && a[31]) ? -a : a;
        mag_b       = (signed_div && b[31]) ? -b : b;
        q_mag       = b_zero ? 32'd0 : mag_a / mag_b;
        r_mag       = b_zero ? 32'd0 : mag_a % mag_b;
        {ph, pl}    = (md_op == MDU_MULT)  ? prod_s :
                      (md_op == MDU_MULTU) ? prod_u :
                      {(signed_div && a[31]) ? -r_mag : r_mag,
                       (signed_div && (a[31] ^ b[31])) ? -q_mag : q_mag};
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage HI/LO multiply/divide unit with fixed multi-cycle latency.
// Results are computed at accept and held pending until the latency counter expires.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [31:0]   hi_q, hi_d, lo_q, lo_d, ph_q, ph_d, pl_q, pl_d;
    logic          dz_q, dz_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   dp_ph, dp_pl;
    logic          dp_dz;
    logic          busy, accept, launch, done;

    mult_div_unit_datapath u_datapath (
        .md_op       (md.MDOp),
        .a           (md.A),
        .b           (md.B),
        .ph          (dp_ph),
        .pl          (dp_pl),
        .div_by_zero (dp_dz)
    );

    always_comb begin
        busy   = cnt_q != '0;
        accept = md.Start && !busy;
        launch = accept && is_long_op(md.MDOp);
        done   = cnt_q == CW'(1);
        cnt_d  = launch ? (is_div_op(md.MDOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) :
                 busy   ? cnt_q - CW'(1) : '0;
        ph_d   = launch ? dp_ph : ph_q;
        pl_d   = launch ? dp_pl : pl_q;
        dz_d   = launch ? dp_dz : dz_q;
        hi_d   = (done && !dz_q)                   ? ph_q :
                 (accept && md.MDOp == MDU_MTHI)   ? md.A : hi_q;
        lo_d   = (done && !dz_q)                   ? pl_q :
                 (accept && md.MDOp == MDU_MTLO)   ? md.A : lo_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            ph_q  <= '0;
            pl_q  <= '0;
            dz_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            ph_q  <= ph_d;
            pl_q  <= pl_d;
            dz_q  <= dz_d;
            cnt_q <= cnt_d;
        end
    end

    assign md.Busy     = busy;
    assign md.StallReq = busy || (md.Start && is_long_op(md.MDOp));
    assign md.HI       = hi_q;
    assign md.LO       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomized checks of mult_div_unit against an arithmetic model.
module tb_mult_div_unit;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total  = 0;
    int   passed = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_unit_if m ();

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (m)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Architectural result of one op, from the instruction-set definition.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      p, q, r;
        logic [63:0] u;
        case (op)
            3'd1: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: begin u = {32'd0, a} * {32'd0, b}; exp_hi = u[63:32]; exp_lo = u[31:0]; end
            3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
            3'd4: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
        logic [31:0] old_hi = exp_hi;
        logic [31:0] old_lo = exp_lo;
        bit          long_op = op inside {3'd1, 3'd2, 3'd3, 3'd4};
        int          n = (op inside {3'd1, 3'd2}) ? 5 : 10;
        int          busy_n = 0;
        bit          changed = 0;
        @(negedge clk);
        m.Start = 1'b1; m.MDOp = op; m.A = a; m.B = b;
        #1;
        total++;
        if (m.StallReq !== long_op) $display("FAIL stallreq op=%0d: got %b expected %b", op, m.StallReq, long_op);
        else passed++;
        model(op, a, b);
        @(posedge clk); #1;
        m.Start = 1'b0; m.MDOp = 3'd0;
        if (long_op) begin
            for (int i = 0; i < 40 && m.Busy === 1'b1; i++) begin
                if (m.HI !== old_hi || m.LO !== old_lo) changed = 1;
                if (inject && i == 2) begin
                    m.Start = 1'b1; m.MDOp = 3'd5; m.A = $urandom | 32'h1;
                    #1;
                    total++;
                    if (m.StallReq !== 1'b1) $display("FAIL stallreq_busy: got %b expected 1", m.StallReq);
                    else passed++;
                end
                busy_n++;
                @(posedge clk); #1;
                m.Start = 1'b0; m.MDOp = 3'd0;
            end
            total++;
            if (busy_n != n) $display("FAIL busy_len op=%0d: got %0d expected %0d", op, busy_n, n);
            else passed++;
            total++;
            if (changed) $display("FAIL early_update op=%0d: HI/LO changed while busy expected held", op);
            else passed++;
        end else begin
            total++;
            if (m.Busy !== 1'b0) $display("FAIL busy_short op=%0d: got %b expected 0", op, m.Busy);
            else passed++;
        end
        total++;
        if (m.HI !== exp_hi) $display("FAIL hi op=%0d a=%h b=%h: got %h expected %h", op, a, b, m.HI, exp_hi);
        else passed++;
        total++;
        if (m.LO !== exp_lo) $display("FAIL lo op=%0d a=%h b=%h: got %h expected %h", op, a, b, m.LO, exp_lo);
        else passed++;
    endtask

    task automatic test_reset();
        m.Start = 1'b0; m.MDOp = 3'd0; m.A = '0; m.B = '0;
        #1;
        total += 4;
        if (m.HI !== 32'd0) $display("FAIL reset_hi: got %h expected 0", m.HI); else passed++;
        if (m.LO !== 32'd0) $display("FAIL reset_lo: got %h expected 0", m.LO); else passed++;
        if (m.Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", m.Busy); else passed++;
        if (m.StallReq !== 1'b0) $display("FAIL reset_stall: got %b expected 0", m.StallReq); else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult();
        do_op(3'd1, 32'hFFFFFFFE, 32'd3, 0);
        do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    endtask

    task automatic test_div();
        do_op(3'd3, 32'hFFFFFFF9, 32'd2, 0);
        do_op(3'd4, 32'd7, 32'd2, 0);
        do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    endtask

    task automatic test_div_zero();
        do_op(3'd5, 32'h12345678, 32'd0, 0);
        do_op(3'd4, 32'd99, 32'd0, 1);
        do_op(3'd3, 32'hDEADBEEF, 32'd0, 0);
    endtask

    task automatic test_move_and_noop();
        do_op(3'd6, 32'd5, 32'd0, 0);
        do_op(3'd0, 32'hAAAA5555, 32'd1, 0);
        do_op(3'd7, 32'h5555AAAA, 32'd1, 0);
    endtask

    task automatic test_reset_mid_op();
        do_op(3'd5, 32'hCAFEF00D, 32'd0, 0);
        @(negedge clk);
        m.Start = 1'b1; m.MDOp = 3'd1; m.A = 32'd6; m.B = 32'd7;
        @(posedge clk); #1;
        m.Start = 1'b0; m.MDOp = 3'd0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        exp_hi = '0; exp_lo = '0;
        total += 3;
        if (m.HI !== 32'd0) $display("FAIL abort_hi: got %h expected 0", m.HI); else passed++;
        if (m.LO !== 32'd0) $display("FAIL abort_lo: got %h expected 0", m.LO); else passed++;
        if (m.Busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", m.Busy); else passed++;
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        total += 3;
        if (m.HI !== 32'd0) $display("FAIL abort_late_hi: got %h expected 0", m.HI); else passed++;
        if (m.LO !== 32'd0) $display("FAIL abort_late_lo: got %h expected 0", m.LO); else passed++;
        if (m.Busy !== 1'b0) $display("FAIL abort_late_busy: got %b expected 0", m.Busy); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  op = 3'($urandom_range(0, 7));
            logic [31:0] a  = $urandom;
            logic [31:0] b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
                              ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            do_op(op, a, b, 0);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_move_and_noop();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
